instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; SHALL be word-aligned.
REQ-002 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 STALL  input  1  downstream hold; while high, the current instruction SHALL NOT retire.
REQ-005 JUMP  input  1  unconditional redirect request, from control.
REQ-006 BRANCH_TAKEN  input  1  resolved taken-branch request, from control.
REQ-007 OFFSET  input  8  signed word offset; this is the instruction's jump/branch field, bits 23:16.
REQ-008 IMEM_READ  output  1  instruction-memory read request.
REQ-009 IMEM_ADDR  output  32  byte address of the fetch; SHALL equal PC at all times.
REQ-010 IMEM_RDATA  input  32  instruction word returned by memory.
REQ-011 IMEM_BUSYWAIT  input  1  memory not ready; high means IMEM_RDATA is invalid.
REQ-012 INSTRUCTION  output  32  registered instruction word, driven to the decoder.
REQ-013 INSTR_VALID  output  1  INSTRUCTION is valid for execution this cycle.
REQ-014 PC  output  32  address of the instruction being fetched or held.
REQ-015 INSTR_COUNT  output  16  count of retired instructions.

Function
REQ-016 FSM states SHALL be IDLE, REQ and EXEC, and the FSM SHALL hold exactly one state at a time.
REQ-017 IDLE: IMEM_READ=0 and INSTR_VALID=0; next state SHALL be REQ unconditionally on the first edge with RESET low.
REQ-018 REQ: IMEM_READ=1 and IMEM_ADDR=PC, with both held stable until the edge that captures the instruction.
REQ-019 REQ: on an edge with IMEM_BUSYWAIT=0, INSTRUCTION<=IMEM_RDATA and the FSM SHALL go to EXEC.
REQ-020 REQ: on an edge with IMEM_BUSYWAIT=1, the FSM SHALL stay in REQ with no timeout.
REQ-021 EXEC: IMEM_READ=0 and INSTR_VALID=1; INSTRUCTION and PC SHALL be held.
REQ-022 EXEC with STALL=1 at an edge: the FSM SHALL remain in EXEC, with all state unchanged and JUMP/BRANCH_TAKEN ignored.
REQ-023 EXEC with STALL=0 at an edge: the instruction retires, PC<=next PC, INSTR_COUNT<=INSTR_COUNT+1, and the FSM SHALL go to REQ.
REQ-024 Next PC SHALL be PC+4 when JUMP=0 and BRANCH_TAKEN=0.
REQ-025 Next PC SHALL be PC+4+(sign_extend(OFFSET)<<2) when JUMP=1 or BRANCH_TAKEN=1; when both are high the result SHALL be identical.
REQ-026 PC arithmetic SHALL be modulo 2^32 and wrap silently; PC[1:0] SHALL remain 2'b00.
REQ-027 INSTR_COUNT SHALL wrap from 16'hFFFF to 16'h0000.
REQ-028 JUMP, BRANCH_TAKEN, OFFSET and STALL SHALL be ignored in IDLE and REQ.
REQ-029 INSTRUCTION SHALL retain its last captured value outside EXEC.
REQ-030 Latency: at most one instruction SHALL be in flight.
REQ-031 Latency: minimum 2 cycles per instruction (1 REQ + 1 EXEC) with zero-wait memory and STALL=0.
REQ-032 Latency: an N-cycle busywait SHALL add exactly N cycles.

Reset
REQ-033 RESET high SHALL immediately, without waiting for CLK, force: state=IDLE, PC=RESET_PC, INSTRUCTION=32'h0, INSTR_VALID=0, IMEM_READ=0, INSTR_COUNT=0.
REQ-034 A reset during REQ or EXEC SHALL abandon the in-flight fetch or instruction without retiring it; memory data arriving after reset SHALL be discarded.
REQ-035 Fetching SHALL resume from RESET_PC via IDLE after RESET deasserts.

Verification
REQ-036 Reset, then zero-wait memory with STALL=0 -> IMEM_ADDR 0x0, 0x4, 0x8; INSTR_VALID high every second cycle; INSTR_COUNT=3 after three EXEC exits.
REQ-037 IMEM_BUSYWAIT high 3 edges at PC=0x4 -> IMEM_READ high 4 cycles with IMEM_ADDR=0x4 stable; INSTRUCTION=IMEM_RDATA sampled at the 4th edge.
REQ-038 EXEC at PC=0x10, JUMP=1, OFFSET=8'hFE -> next IMEM_ADDR=0x0C.
REQ-039 EXEC at PC=0x20, BRANCH_TAKEN=1, OFFSET=8'h03, STALL=1 for 2 edges -> PC held 2 cycles with INSTR_VALID=1 and INSTR_COUNT unchanged; after STALL=0, PC=0x30.
REQ-040 RESET_PC=32'hFFFF_FFFC, no redirect -> next PC=32'h0000_0000.
REQ-041 RESET pulsed mid-REQ between edges -> IMEM_READ=0 and PC=RESET_PC immediately; a late IMEM_RDATA is not captured; INSTR_COUNT=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Single-issue instruction fetch unit: requests one word at PC, holds it for
// execution until the stage downstream releases it, then advances PC.
//
// state | meaning
// IDLE  | out of reset, no request issued yet
// REQ   | read request at PC outstanding, waiting for memory ready
// EXEC  | instruction captured and valid, waiting for stall to drop
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [7:0]  offset,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_busywait,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [15:0] instr_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_inc;
  logic [31:0] br_disp;
  logic [31:0] pc_next;

  // Offset is in words; scaling by 4 keeps PC[1:0] at zero.
  assign br_disp = {{22{offset[7]}}, offset, 2'b00};
  assign pc_inc  = pc + 32'd4;
  assign pc_next = (jump || branch_taken) ? (pc_inc + br_disp) : pc_inc;

  assign imem_read   = (state == REQ);
  assign instr_valid = (state == EXEC);
  assign imem_addr   = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= 32'h0;
      instr_count <= 16'h0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (!imem_busywait) begin
            instruction <= imem_rdata;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc          <= pc_next;
            instr_count <= instr_count + 16'd1;
            state       <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: captured words go through a scoreboard queue, PC and
// retire count are tracked by a small reference model.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump;
  logic        branch_taken;
  logic [7:0]  offset;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_busywait;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [15:0] instr_count;

  logic        hi_imem_read;
  logic [31:0] hi_imem_addr;
  logic [31:0] hi_instruction;
  logic        hi_instr_valid;
  logic [31:0] hi_pc;
  logic [15:0] hi_instr_count;

  int checks;
  int failures;
  logic [31:0] exp_pc;
  logic [15:0] exp_count;
  logic [31:0] sb_q[$];

  instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump),
    .branch_taken(branch_taken), .offset(offset),
    .imem_read(imem_read), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_busywait(imem_busywait), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .instr_count(instr_count)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk(clk), .reset(reset), .stall(1'b0), .jump(1'b0),
    .branch_taken(1'b0), .offset(8'h00),
    .imem_read(hi_imem_read), .imem_addr(hi_imem_addr),
    .imem_rdata(32'h1234_5678), .imem_busywait(1'b0),
    .instruction(hi_instruction), .instr_valid(hi_instr_valid),
    .pc(hi_pc), .instr_count(hi_instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Entered at a negedge with the DUT in REQ; leaves at a negedge back in REQ.
  task automatic fetch(input int waits, input logic j, input logic b,
                       input logic [7:0] off, input int stalls);
    logic [31:0] d;
    jump = 1'b1; branch_taken = 1'b1; offset = 8'h55; stall = 1'b1;
    for (int i = 0; i < waits; i++) begin
      chk("req_read", {31'b0, imem_read}, 32'd1);
      chk("req_addr", imem_addr, exp_pc);
      chk("req_valid", {31'b0, instr_valid}, 32'd0);
      imem_busywait = 1'b1;
      imem_rdata = $urandom;
      @(negedge clk);
    end
    chk("req_read", {31'b0, imem_read}, 32'd1);
    chk("req_addr", imem_addr, exp_pc);
    d = $urandom;
    imem_busywait = 1'b0;
    imem_rdata = d;
    sb_q.push_back(d);
    @(negedge clk);
    imem_busywait = 1'b1;
    imem_rdata = ~d;
    chk("exec_valid", {31'b0, instr_valid}, 32'd1);
    chk("exec_read", {31'b0, imem_read}, 32'd0);
    chk("sb_depth", sb_q.size(), 32'd1);
    if (sb_q.size() > 0) chk("instr", instruction, sb_q.pop_front());
    chk("exec_pc", pc, exp_pc);
    stall = 1'b1; jump = 1'b1; offset = 8'h40;
    for (int i = 0; i < stalls; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc", pc, exp_pc);
      chk("stall_count", {16'b0, instr_count}, {16'b0, exp_count});
      chk("stall_instr", instruction, d);
    end
    stall = 1'b0; jump = j; branch_taken = b; offset = off;
    @(negedge clk);
    exp_pc = exp_pc + 32'd4 + ((j || b) ? {{22{off[7]}}, off, 2'b00} : 32'd0);
    exp_count = exp_count + 16'd1;
    chk("next_addr", imem_addr, exp_pc);
    chk("count", {16'b0, instr_count}, {16'b0, exp_count});
    chk("retire_valid", {31'b0, instr_valid}, 32'd0);
    chk("retire_read", {31'b0, imem_read}, 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    offset = 8'h00; imem_rdata = 32'h0; imem_busywait = 1'b0;
    exp_pc = 32'h0; exp_count = 16'h0;
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_read", {31'b0, imem_read}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_count", {16'b0, instr_count}, 32'd0);
    chk("rst_hi_pc", hi_pc, 32'hFFFF_FFFC);
    reset = 1'b0;
    chk("idle_read", {31'b0, imem_read}, 32'd0);
    chk("idle_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);

    fetch(0, 1'b0, 1'b0, 8'h00, 0);
    chk("hi_wrap_pc", hi_pc, 32'h0000_0000);
    chk("hi_count", {16'b0, hi_instr_count}, 32'd1);
    fetch(3, 1'b0, 1'b0, 8'h00, 0);
    fetch(0, 1'b0, 1'b0, 8'h00, 0);
    chk("count_three", {16'b0, instr_count}, 32'd3);
    fetch(0, 1'b0, 1'b0, 8'h00, 0);
    chk("pc_0x10", pc, 32'h10);
    fetch(1, 1'b1, 1'b0, 8'hFE, 0);
    chk("jump_back", imem_addr, 32'h0C);
    fetch(0, 1'b1, 1'b0, 8'h04, 0);
    chk("pc_0x20", pc, 32'h20);
    fetch(0, 1'b0, 1'b1, 8'h03, 2);
    chk("branch_0x30", pc, 32'h30);
    fetch(2, 1'b1, 1'b1, 8'h80, 1);
    chk("pc_wrap_neg", pc, 32'hFFFF_FE34);
    fetch(0, 1'b0, 1'b1, 8'h7F, 0);

    imem_busywait = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_read", {31'b0, imem_read}, 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_count", {16'b0, instr_count}, 32'd0);
    chk("midrst_instr", instruction, 32'h0);
    imem_busywait = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("late_data", instruction, 32'h0);
    reset = 1'b0;
    chk("resume_idle", {31'b0, imem_read}, 32'd0);
    @(negedge clk);
    chk("resume_read", {31'b0, imem_read}, 32'd1);
    chk("resume_addr", imem_addr, 32'h0);
    chk("resume_instr", instruction, 32'h0);
    exp_pc = 32'h0;
    exp_count = 16'h0;
    fetch(1, 1'b0, 1'b0, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
